arb_req_ctrl: RTL and testbench

ARB_REQ_CTRL -- requirements
Module: arb_req_ctrl

---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_req_chan.sv | 47 ++++
 rtl/arb_req_ctrl.sv | 97 +++++++++
 tb/tb_arb_req_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared configuration for the request/beat controller that sits in front of
// the round-robin arbiter: default port count, beat-count field width and the
// derived index / counter types.
package arb_pkg;

  localparam int unsigned ARB_WIDTH = 4;
  localparam int unsigned ARB_LEN_W = 4;
  localparam int unsigned ARB_IDX_W = (ARB_WIDTH > 1) ? $clog2(ARB_WIDTH) : 1;

  // Index of one requester port.
  typedef logic [ARB_IDX_W-1:0] port_idx_t;

  // Beats outstanding on one port; one bit wider than the length field because
  // a length L encodes L+1 beats.
  typedef logic [ARB_LEN_W:0] beat_cnt_t;

endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: holds the beats still owed to the current job, offers
// acceptance only when idle and requests the arbiter whenever beats remain.
// All outputs derive from the registered count, never from the grant.
module arb_req_chan
  import arb_pkg::*;
#(
  parameter int unsigned LEN_W = ARB_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  input  logic             beat_take,
  output logic             job_ready,
  output logic             request,
  output logic             beat_last
);

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  logic [LEN_W:0] remaining_q;
  logic [LEN_W:0] remaining_d;

  assign job_ready = (remaining_q == '0);
  assign request   = (remaining_q != '0);
  assign beat_last = (remaining_q == CNT_ONE);

  // Load a new job when idle, otherwise count down one beat per usable grant.
  always_comb begin
    remaining_d = remaining_q;
    if (job_valid && job_ready) begin
      remaining_d = {1'b0, job_len} + CNT_ONE;
    end else if (beat_take && request) begin
      remaining_d = remaining_q - CNT_ONE;
    end
  end

  // Beat counter register; reset discards any outstanding beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining_q <= '0;
    end else begin
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: rtl/arb_req_ctrl.sv
// Request/beat controller in front of a round-robin arbiter. Each port turns an
// accepted job into a run of single-cycle beats, one per grant. Because the
// arbiter answers two edges late, grants that land on an already-finished port
// are counted rather than treated as errors; multi-hot grants are flagged.
module arb_req_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = ARB_WIDTH,
  parameter int unsigned LEN_W = ARB_LEN_W,
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            job_valid,
  input  logic [WIDTH-1:0][LEN_W-1:0] job_len,
  output logic [WIDTH-1:0]            job_ready,
  output logic [WIDTH-1:0]            request,
  input  logic [WIDTH-1:0]            grant,
  output logic                        beat_valid,
  output logic [IDX_W-1:0]            beat_port,
  output logic                        beat_last,
  output logic [WIDTH-1:0]            job_done,
  output logic                        err_multi,
  output logic [7:0]                  excess_cnt
);

  localparam logic [WIDTH-1:0] GRANT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] take;
  logic [WIDTH-1:0] chan_last;
  logic             grant_multi;
  logic             grant_one_hot;
  logic             hit;
  logic [IDX_W-1:0] beat_idx;
  logic             err_multi_q, err_multi_d;
  logic [7:0]       excess_q, excess_d;

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign grant_multi   = |(grant & (grant - GRANT_ONE));
  assign grant_one_hot = (grant != '0) && !grant_multi;
  assign take          = grant_one_hot ? grant : '0;
  assign hit           = |(take & request);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    arb_req_chan #(
      .LEN_W(LEN_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .job_valid(job_valid[i]),
      .job_len  (job_len[i]),
      .beat_take(take[i]),
      .job_ready(job_ready[i]),
      .request  (request[i]),
      .beat_last(chan_last[i])
    );
  end

  // Encode the single granted port; take is one-hot or zero here.
  always_comb begin
    beat_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (take[i]) begin
        beat_idx = IDX_W'(i);
      end
    end
  end

  assign beat_valid = hit;
  assign beat_port  = hit ? beat_idx : '0;
  assign beat_last  = hit && |(take & chan_last);
  assign job_done   = beat_last ? take : '0;

  // Sticky multi-grant flag and saturating count of grants to idle ports.
  always_comb begin
    err_multi_d = err_multi_q | grant_multi;
    excess_d    = excess_q;
    if (grant_one_hot && !hit && (excess_q != 8'hFF)) begin
      excess_d = excess_q + 8'd1;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_multi_q <= 1'b0;
      excess_q    <= 8'd0;
    end else begin
      err_multi_q <= err_multi_d;
      excess_q    <= excess_d;
    end
  end

  assign err_multi  = err_multi_q;
  assign excess_cnt = excess_q;

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Bench for arb_req_ctrl: a behavioural round-robin arbiter (request sampled on
// one edge, registered grant on the next) closes the loop; a grant override is
// used for multi-hot and saturation cases. Expected beats are queued per port
// by the stimulus and consumed by an independent monitor.
module tb_arb_req_ctrl;
  import arb_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      job_valid;
  logic [3:0][3:0] job_len;
  logic [3:0]      job_ready;
  logic [3:0]      request;
  logic [3:0]      grant;
  logic            beat_valid;
  port_idx_t       beat_port;
  logic            beat_last;
  logic [3:0]      job_done;
  logic            err_multi;
  logic [7:0]      excess_cnt;

  logic [3:0] arb_req_q, arb_grant, inj_grant;
  logic [1:0] arb_ptr;
  logic       inj_en;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_cyc = -1;
  int prev_port = -1;
  bit exp_q [4][$];

  always #5 clk = ~clk;

  assign grant = inj_en ? inj_grant : arb_grant;

  arb_req_ctrl #(.WIDTH(4), .LEN_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .job_valid (job_valid),
    .job_len   (job_len),
    .job_ready (job_ready),
    .request   (request),
    .grant     (grant),
    .beat_valid(beat_valid),
    .beat_port (beat_port),
    .beat_last (beat_last),
    .job_done  (job_done),
    .err_multi (err_multi),
    .excess_cnt(excess_cnt)
  );

  function automatic logic [3:0] rr_pick(logic [3:0] r, logic [1:0] p);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (int'(p) + k) % 4;
      if (r[idx]) return 4'(1 << idx);
    end
    return 4'b0000;
  endfunction

  function automatic logic [1:0] rr_next(logic [3:0] r, logic [1:0] p);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (int'(p) + k) % 4;
      if (r[idx]) return 2'((idx + 1) % 4);
    end
    return p;
  endfunction

  // Reference round-robin arbiter with a one-stage request sample.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      arb_req_q <= 4'b0000;
      arb_grant <= 4'b0000;
      arb_ptr   <= 2'd0;
    end else begin
      arb_req_q <= request;
      arb_grant <= rr_pick(arb_req_q, arb_ptr);
      arb_ptr   <= rr_next(arb_req_q, arb_ptr);
    end
  end

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int qtotal();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
  endfunction

  // Monitor: every issued beat must match the head of its port's queue.
  always @(negedge clk) begin
    int p;
    int busy;
    bit e;
    if (!reset) begin
      check("rst_beat_valid", beat_valid, 0);
      check("rst_job_done", job_done, 0);
    end else if (beat_valid) begin
      p = int'(beat_port);
      busy = 0;
      for (int k = 0; k < 4; k++) if (exp_q[k].size() != 0) busy++;
      if (exp_q[p].size() == 0) begin
        check("unexpected_beat_port", p, 99);
      end else begin
        e = exp_q[p].pop_front();
        check("beat_last", beat_last, e);
        check("job_done_vec", job_done, e ? (1 << p) : 0);
        if (busy > 1 && prev_port >= 0) begin
          tests++;
          if (p == prev_port) begin
            fails++;
            $display("FAIL rr_distinct: got port %0d expected not %0d", p, prev_port);
          end
        end
      end
      prev_port = p;
      if (beat_last) begin
        done_cnt++;
        last_cyc = cyc;
      end
    end else begin
      check("idle_job_done", job_done, 0);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(int max, string name);
    int k;
    k = 0;
    while (k < max && qtotal() != 0) begin
      tick(1);
      k++;
    end
    check(name, qtotal(), 0);
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_job_ready"}, job_ready, 4'b1111);
    check({tag, "_request"}, request, 0);
    check({tag, "_beat_valid"}, beat_valid, 0);
    check({tag, "_beat_port"}, beat_port, 0);
    check({tag, "_beat_last"}, beat_last, 0);
    check({tag, "_job_done"}, job_done, 0);
    check({tag, "_err_multi"}, err_multi, 0);
    check({tag, "_excess"}, excess_cnt, 0);
  endtask

  initial begin
    int d0;
    int e0;
    int acc;
    reset     = 1'b0;
    job_valid = 4'b0000;
    job_len   = '0;
    inj_en    = 1'b0;
    inj_grant = 4'b0000;
    tick(3);
    check_reset_values("por");
    reset = 1'b1;
    tick(2);
    check("post_rel_ready", job_ready, 4'b1111);

    // Single job on port 2, length 3 -> four beats, two trailing grants.
    d0 = done_cnt; e0 = excess_cnt; prev_port = -1;
    exp_q[2].push_back(1'b0); exp_q[2].push_back(1'b0);
    exp_q[2].push_back(1'b0); exp_q[2].push_back(1'b1);
    job_len[2] = 4'd3; job_valid = 4'b0100;
    tick(1);
    check("s1_busy", job_ready[2], 0);
    check("s1_request", request, 4'b0100);
    job_valid = 4'b0000;
    drain(40, "s1_drain");
    tick(6);
    check("s1_ready", job_ready, 4'b1111);
    check("s1_done", done_cnt - d0, 1);
    check("s1_excess", int'(excess_cnt) - e0, 2);

    // Lone length-0 job on port 1 -> one beat then two overshoot grants.
    d0 = done_cnt; e0 = excess_cnt; prev_port = -1;
    exp_q[1].push_back(1'b1);
    job_len[1] = 4'd0; job_valid = 4'b0010;
    tick(1);
    job_valid = 4'b0000;
    drain(20, "s2_drain");
    tick(6);
    check("s2_done", done_cnt - d0, 1);
    check("s2_excess", int'(excess_cnt) - e0, 2);

    // Fairness: all four ports offer two-beat jobs together.
    d0 = done_cnt; prev_port = -1;
    for (int k = 0; k < 4; k++) begin
      exp_q[k].push_back(1'b0);
      exp_q[k].push_back(1'b1);
      job_len[k] = 4'd1;
    end
    job_valid = 4'b1111;
    tick(1);
    job_valid = 4'b0000;
    drain(60, "s3_drain");
    tick(8);
    check("s3_done", done_cnt - d0, 4);
    check("s3_ready", job_ready, 4'b1111);

    // Back-to-back on port 3: second job accepted the cycle after beat_last.
    d0 = done_cnt; prev_port = -1; acc = -1; last_cyc = -1;
    exp_q[3].push_back(1'b0); exp_q[3].push_back(1'b1); exp_q[3].push_back(1'b1);
    job_len[3] = 4'd1; job_valid = 4'b1000;
    tick(1);
    job_len[3] = 4'd0;
    for (int k = 0; k < 40; k++) begin
      if (job_ready[3]) begin
        acc = cyc;
        break;
      end
      tick(1);
    end
    tick(1);
    job_valid = 4'b0000;
    check("s4_accept_cycle", acc, last_cyc + 1);
    drain(40, "s4_drain");
    tick(6);
    check("s4_done", done_cnt - d0, 2);

    // Multi-hot grant injection on a busy port 1.
    inj_en = 1'b1; inj_grant = 4'b0000; prev_port = -1;
    tick(2);
    job_len[1] = 4'd2; job_valid = 4'b0010;
    tick(1);
    job_valid = 4'b0000;
    e0 = excess_cnt;
    inj_grant = 4'b0110;
    tick(1);
    check("s5_err_set", err_multi, 1);
    tick(1);
    check("s5_request_kept", request, 4'b0010);
    check("s5_excess_kept", excess_cnt, e0);
    exp_q[1].push_back(1'b0); exp_q[1].push_back(1'b0); exp_q[1].push_back(1'b1);
    inj_grant = 4'b0010;
    tick(3);
    inj_grant = 4'b0000;
    check("s5_three_beats", qtotal(), 0);
    check("s5_ready", job_ready, 4'b1111);
    check("s5_err_sticky", err_multi, 1);
    check("s5_excess_final", excess_cnt, e0);

    // Saturation of the overshoot counter via a grant to idle port 0.
    e0 = excess_cnt;
    inj_grant = 4'b0001;
    tick(10);
    check("s6_excess_step", excess_cnt, e0 + 10);
    tick(260);
    check("s6_excess_sat", excess_cnt, 255);
    tick(2);
    check("s6_excess_hold", excess_cnt, 255);
    inj_grant = 4'b0000;
    inj_en = 1'b0;
    tick(4);

    // Reset pulled low mid-job with five beats left on port 0.
    prev_port = -1;
    exp_q[0].push_back(1'b0); exp_q[0].push_back(1'b0); exp_q[0].push_back(1'b0);
    job_len[0] = 4'd7; job_valid = 4'b0001;
    tick(1);
    job_valid = 4'b0000;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      if (exp_q[0].size() == 0) break;
    end
    check("s7_three_beats", exp_q[0].size(), 0);
    d0 = done_cnt;
    #2 reset = 1'b0;
    #1;
    check_reset_values("s7_async");
    tick(2);
    reset = 1'b1;
    tick(3);
    check("s7_ready", job_ready, 4'b1111);
    check("s7_no_done", done_cnt - d0, 0);
    check("s7_excess_clear", excess_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
